des_board_io: RTL and testbench

- Board-side front end for the DES pipeline on the DE2-115.
- Collects a 64-bit data block and a 64-bit key from SW[15:0], entered 16 bits at a time on debounced push-button presses.
- Pulses start into the DES core, captures its 64-bit result, and drives HEX0-HEX7 and LEDR.
- Sits between the board pins and the DES core inside the top-level pipeline.

---
 rtl/des_board_io_if.sv | 19 +
 rtl/des_board_io.sv | 251 +++++++++++++++++++++++++
 tb/tb_des_board_io.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/des_board_io_if.sv
// Bus between the board front end and the DES core.
interface des_board_io_if;
  logic        des_start;
  logic        des_decrypt;
  logic [63:0] des_data;
  logic [63:0] des_key;
  logic        des_done;
  logic [63:0] des_result;

  modport master (
    output des_start, des_decrypt, des_data, des_key,
    input  des_done, des_result
  );

  modport slave (
    input  des_start, des_decrypt, des_data, des_key,
    output des_done, des_result
  );
endinterface

// File: rtl/des_board_io.sv
// Board-side front end for the DES core: debounced button entry of data/key from the
// switches, start pulse, result capture and HEX/LED display.
// Optional: define DES_IO_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES.
module des_board_io #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       sw,
  input  logic [2:0]        key_n,
  des_board_io_if.master    des,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3,
  output logic [6:0]        hex4,
  output logic [6:0]        hex5,
  output logic [6:0]        hex6,
  output logic [6:0]        hex7,
  output logic [17:0]       ledr
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {StLoadData, StLoadKey, StStart, StWait, StShow} state_e;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
  endfunction

  // Word 0 lands in the most significant 16 bits.
  function automatic logic [63:0] put_word(input logic [63:0] w, input logic [1:0] idx,
                                           input logic [15:0] v);
    logic [63:0] r;
    r = w;
    case (idx)
      2'd0:    r[63:48] = v;
      2'd1:    r[47:32] = v;
      2'd2:    r[31:16] = v;
      default: r[15:0]  = v;
    endcase
    return r;
  endfunction

  // ---------------- Button synchronizer and debouncer ----------------
  logic [2:0]          sync1_q, sync2_q, level_q, level_d, press_q, press_d;
  logic [2:0][DbW-1:0] cnt_q, cnt_d;

  // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DbLast) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    press_d = level_q & ~level_d;
  end

  // Synchronizer, accepted levels (released = 1) and one-cycle press pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      level_q <= '1;
      cnt_q   <= '0;
      press_q <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  logic enter, page, mode;
  assign enter = press_q[0];
  assign page  = press_q[1];
  assign mode  = press_q[2];

  // ---------------- Control FSM ----------------
  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             page_q, page_d, decrypt_q, decrypt_d, start_q, start_d;
  logic [63:0]      data_q, data_d, key_q, key_d, result_q, result_d;
  logic [7:0][6:0]  hex_q, hex_d;
  logic [17:0]      ledr_q, ledr_d;
`ifdef DES_IO_TIMEOUT_EN
  logic [31:0]      wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic [22:0]      blink_q, blink_d;
`else
  logic [31:0]      unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  // Next-state logic; ENTER has priority over PAGE in SHOW.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    page_d    = page_q;
    decrypt_d = decrypt_q;
    data_d    = data_q;
    key_d     = key_q;
    result_d  = result_q;
`ifdef DES_IO_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    blink_d    = blink_q + 1'b1;
`endif
    case (state_q)
      StLoadData, StLoadKey: begin
        if (mode) decrypt_d = ~decrypt_q;
        if (enter) begin
          if (state_q == StLoadData) data_d = put_word(data_q, idx_q, sw);
          else                       key_d  = put_word(key_q, idx_q, sw);
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = (state_q == StLoadData) ? StLoadKey : StStart;
        end
      end
      StStart: begin
        state_d = StWait;
`ifdef DES_IO_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      StWait: begin
        if (des.des_done) begin
          result_d = des.des_result;
          state_d  = StShow;
`ifdef DES_IO_TIMEOUT_EN
        end else if (wait_cnt_q == TIMEOUT_CYCLES - 1) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = StShow;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
`endif
        end
      end
      StShow: begin
        if (enter) begin
          state_d = StLoadData;
          idx_d   = '0;
          page_d  = 1'b0;
`ifdef DES_IO_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end else if (page) begin
          page_d = ~page_q;
        end
      end
      default: state_d = StLoadData;
    endcase
    start_d = (state_d == StStart);
  end

  // Display and LED contents for the upcoming state.
  always_comb begin
    logic [31:0] half;
    logic        led17;
    half  = page_d ? result_d[31:0] : result_d[63:32];
    hex_d = {8{7'h7F}};
    case (state_d)
      StLoadData, StLoadKey: begin
        hex_d[7] = seg((state_d == StLoadKey) ? 4'd1 : 4'd0);
        hex_d[6] = seg({2'b00, idx_d});
        hex_d[3] = seg(sw[15:12]);
        hex_d[2] = seg(sw[11:8]);
        hex_d[1] = seg(sw[7:4]);
        hex_d[0] = seg(sw[3:0]);
      end
      StShow: begin
        for (int i = 0; i < 8; i++) hex_d[i] = seg(half[i*4 +: 4]);
      end
      default: hex_d[7] = seg(4'd2);
    endcase
`ifdef DES_IO_TIMEOUT_EN
    led17 = (state_d == StShow) & ~(err_d & blink_q[22]);
`else
    led17 = (state_d == StShow);
`endif
    ledr_d = {led17, decrypt_d, sw};
  end

  // All FSM state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StLoadData;
      idx_q     <= '0;
      page_q    <= 1'b0;
      decrypt_q <= 1'b0;
      start_q   <= 1'b0;
      data_q    <= '0;
      key_q     <= '0;
      result_q  <= '0;
      hex_q     <= {8{7'h7F}};
      ledr_q    <= '0;
`ifdef DES_IO_TIMEOUT_EN
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      blink_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      page_q    <= page_d;
      decrypt_q <= decrypt_d;
      start_q   <= start_d;
      data_q    <= data_d;
      key_q     <= key_d;
      result_q  <= result_d;
      hex_q     <= hex_d;
      ledr_q    <= ledr_d;
`ifdef DES_IO_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      blink_q    <= blink_d;
`endif
    end
  end

  assign des.des_start   = start_q;
  assign des.des_decrypt = decrypt_q;
  assign des.des_data    = data_q;
  assign des.des_key     = key_q;
  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign hex6 = hex_q[6];
  assign hex7 = hex_q[7];
  assign ledr = ledr_q;

endmodule

// File: tb/tb_des_board_io.sv
// Scoreboard bench for des_board_io: stimulus pushes expected snapshots and start
// transactions; a negedge monitor pops and compares them.
module tb_des_board_io;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw;
  logic [2:0]  key_n;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [17:0] ledr;

  des_board_io_if bus();

  always #5 clk = ~clk;

  des_board_io #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .sw(sw), .key_n(key_n), .des(bus),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7), .ledr(ledr)
  );

  localparam logic [63:0] D1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] K1 = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] D2 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] R1 = 64'h85E8_1354_0F0A_B405;

  typedef struct {
    string       name;
    logic [55:0] hex;
    logic [17:0] ledr;
    logic [63:0] data;
    logic [63:0] key;
  } snap_t;
  typedef struct {
    logic [63:0] data;
    logic [63:0] key;
    logic        dec;
  } start_t;

  snap_t  snap_q[$];
  start_t start_q[$];
  int     checks = 0;
  int     errors = 0;
  int     snap_reqs = 0;
  int     snap_done = 0;
  int     done_reqs = 0;
  int     done_served = 0;
  int     start_count = 0;
  logic   start_prev = 1'b0;
  bit     core_en = 1'b0;
  bit     final_req = 1'b0;
  bit     final_done = 1'b0;

  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [6:0] seg(input logic [3:0] n);
    return font[n];
  endfunction

  function automatic logic [55:0] load_disp(input logic [3:0] st, input logic [3:0] idx,
                                            input logic [15:0] s);
    return {seg(st), seg(idx), 7'h7F, 7'h7F, seg(s[15:12]), seg(s[11:8]), seg(s[7:4]),
            seg(s[3:0])};
  endfunction

  function automatic logic [55:0] show_disp(input logic [31:0] h);
    return {seg(h[31:28]), seg(h[27:24]), seg(h[23:20]), seg(h[19:16]),
            seg(h[15:12]), seg(h[11:8]), seg(h[7:4]), seg(h[3:0])};
  endfunction

  function automatic logic [55:0] wait_disp();
    return {seg(4'd2), {7{7'h7F}}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: snapshots, start transactions and end-of-run totals.
  always @(negedge clk) begin
    snap_t  s;
    start_t st;
    if (snap_done < snap_reqs) begin
      if (snap_q.size() == 0) begin
        chk("snap_queue", 64'(snap_q.size()), 64'd1);
      end else begin
        s = snap_q.pop_front();
        chk({s.name, "_hex"}, 64'({hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0}),
            64'(s.hex));
        chk({s.name, "_ledr"}, 64'(ledr), 64'(s.ledr));
        chk({s.name, "_data"}, bus.des_data, s.data);
        chk({s.name, "_key"}, bus.des_key, s.key);
      end
      snap_done++;
    end
    if (bus.des_start) begin
      start_count++;
      chk("start_single_cycle", 64'(start_prev), 64'd0);
      if (start_q.size() == 0) begin
        chk("start_unexpected", 64'(start_q.size()), 64'd1);
      end else begin
        st = start_q.pop_front();
        chk("start_data", bus.des_data, st.data);
        chk("start_key", bus.des_key, st.key);
        chk("start_decrypt", 64'(bus.des_decrypt), 64'(st.dec));
      end
    end
    start_prev = bus.des_start;
    if (final_req && !final_done) begin
      chk("start_count", 64'(start_count), 64'd2);
      chk("start_queue_drained", 64'(start_q.size()), 64'd0);
      final_done = 1'b1;
    end
  end

  // Core model: fixed result 16 cycles after start, plus on-request stray done pulses.
  initial begin
    bus.des_done   = 1'b0;
    bus.des_result = '0;
    forever begin
      @(negedge clk);
      if (bus.des_start && core_en) begin
        repeat (16) @(posedge clk);
        #1 bus.des_done = 1'b1;
        bus.des_result = R1;
        @(posedge clk);
        #1 bus.des_done = 1'b0;
        bus.des_result = '0;
      end else if (done_served < done_reqs) begin
        done_served++;
        @(posedge clk);
        #1 bus.des_done = 1'b1;
        bus.des_result = R1;
        @(posedge clk);
        #1 bus.des_done = 1'b0;
        bus.des_result = '0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the selected buttons low long enough to debounce, then release.
  task automatic press(input logic [2:0] m);
    key_n = ~m;
    tick(8);
    key_n = 3'b111;
    tick(8);
  endtask

  task automatic snap(input string n, input logic [55:0] h, input logic [17:0] l,
                      input logic [63:0] d, input logic [63:0] k);
    snap_t s;
    s.name = n; s.hex = h; s.ledr = l; s.data = d; s.key = k;
    snap_q.push_back(s);
    snap_reqs++;
    @(negedge clk);
    #1;
  endtask

  task automatic expect_start(input logic [63:0] d, input logic [63:0] k, input logic dec);
    start_t s;
    s.data = d; s.key = k; s.dec = dec;
    start_q.push_back(s);
  endtask

  initial begin
    reset = 1'b1;
    sw    = 16'h0000;
    key_n = 3'b111;
    tick(3);
    reset = 1'b0;
    tick(3);
    snap("reset", load_disp(4'd0, 4'd0, 16'h0000), 18'h0, 64'h0, 64'h0);

    // Debounce: short glitch ignored; chatter then stable low gives one ENTER.
    sw = 16'h0123;
    key_n[0] = 1'b0; tick(2); key_n[0] = 1'b1; tick(12);
    snap("glitch", load_disp(4'd0, 4'd0, 16'h0123), {2'b00, 16'h0123}, 64'h0, 64'h0);
    key_n[0] = 1'b0; tick(1); key_n[0] = 1'b1; tick(1);
    key_n[0] = 1'b0; tick(8); key_n[0] = 1'b1; tick(8);
    snap("chatter", load_disp(4'd0, 4'd1, 16'h0123), {2'b00, 16'h0123},
         64'h0123_0000_0000_0000, 64'h0);

    // Full encrypt pass.
    core_en = 1'b1;
    sw = 16'h4567; press(3'b001);
    sw = 16'h89AB; press(3'b001);
    sw = 16'hCDEF; press(3'b001);
    snap("data_loaded", load_disp(4'd1, 4'd0, 16'hCDEF), {2'b00, 16'hCDEF}, D1, 64'h0);
    sw = 16'h1334; press(3'b001);
    sw = 16'h5779; press(3'b001);
    sw = 16'h9BBC; press(3'b001);
    expect_start(D1, K1, 1'b0);
    sw = 16'hDFF1; press(3'b001);
    snap("wait", wait_disp(), {2'b00, 16'hDFF1}, D1, K1);
    tick(16);
    snap("show_hi", show_disp(R1[63:32]), {2'b10, 16'hDFF1}, D1, K1);
    press(3'b010);
    snap("show_lo", show_disp(R1[31:0]), {2'b10, 16'hDFF1}, D1, K1);
    press(3'b100);
    snap("mode_in_show", show_disp(R1[31:0]), {2'b10, 16'hDFF1}, D1, K1);
    press(3'b011);
    snap("enter_page", load_disp(4'd0, 4'd0, 16'hDFF1), {2'b00, 16'hDFF1}, D1, K1);

    // Second pass: MODE gating, then reset while the operation is pending.
    core_en = 1'b0;
    sw = 16'hAAAA; press(3'b001);
    sw = 16'hBBBB; press(3'b001);
    sw = 16'hCCCC; press(3'b001);
    sw = 16'hDDDD; press(3'b001);
    press(3'b100);
    snap("mode_in_key", load_disp(4'd1, 4'd0, 16'hDDDD), {2'b01, 16'hDDDD}, D2, K1);
    sw = 16'h1334; press(3'b001);
    sw = 16'h5779; press(3'b001);
    sw = 16'h9BBC; press(3'b001);
    expect_start(D2, K1, 1'b1);
    sw = 16'hDFF1; press(3'b001);
    press(3'b100);
`ifdef DES_IO_TIMEOUT_EN
    snap("timeout", show_disp(32'h0), {2'b11, 16'hDFF1}, D2, K1);
    done_reqs++;
    tick(4);
    snap("late_done", show_disp(32'h0), {2'b11, 16'hDFF1}, D2, K1);
`else
    snap("mode_in_wait", wait_disp(), {2'b01, 16'hDFF1}, D2, K1);
`endif
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);
    done_reqs++;
    tick(5);
    snap("reset_mid_wait", load_disp(4'd0, 4'd0, 16'hDFF1), {2'b00, 16'hDFF1}, 64'h0, 64'h0);

    tick(2);
    final_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
